// File: rtl/wvb_reader_pkg.sv
// Shared definitions for the waveform buffer drain engine.
// Header bit-field map, output word magic and FSM state encoding.
package wvb_reader_pkg;

    localparam int LTC_LO       = 0;
    localparam int LTC_HI       = 47;
    localparam int START_LO     = 48;
    localparam int STOP_LO      = 63;
    localparam int TRIG_SRC_LO  = 78;
    localparam int CNST_RUN_BIT = 80;

    localparam logic [3:0] HDR_MAGIC = 4'hA;

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        HDR2,
        SAMP,
        DONE
    } state_t;

endpackage

// File: rtl/wvb_rd_skid_fifo.sv
// Small synchronous FIFO with occupancy count.
// Buffers samples returning from the waveform RAM read pipeline.
module wvb_rd_skid_fifo #(
    parameter int W     = 28,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [W-1:0]                 din,
    input  logic                         pop,
    output logic [W-1:0]                 dout,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;

    // Pointer wrap and occupancy update
    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q + CW'(push) - CW'(pop);
        if (push) begin
            wr_d = (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
        end
        if (pop) begin
            rd_d = (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
        end
    end

    // Pointer and count registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // Storage; contents are don't-care while empty
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_q];
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/wvb_reader.sv
// Waveform buffer drain engine: pops a header, emits three header
// words, then streams the event's samples with valid/ready.
module wvb_reader
    import wvb_reader_pkg::*;
#(
    parameter int P_DATA_WIDTH = 28,
    parameter int P_ADR_WIDTH  = 15,
    parameter int P_HDR_WIDTH  = 87,
    parameter int P_LTC_WIDTH  = 48,
    parameter int P_RD_LAT     = 2,
    parameter int P_SKID_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    hdr_empty,
    input  logic [P_HDR_WIDTH-1:0]  hdr_data,
    output logic                    hdr_rdreq,
    input  logic [P_DATA_WIDTH-1:0] wvb_data,
    output logic                    wvb_rdreq,
    output logic                    wvb_rddone,
    output logic [31:0]             dout,
    output logic                    dout_valid,
    input  logic                    dout_ready,
    output logic                    dout_last,
    output logic                    busy,
    output logic [31:0]             evt_cnt
);

    localparam int NW = P_ADR_WIDTH + 1;
    localparam int CW = $clog2(P_SKID_DEPTH + 1);

    state_t state_q, state_d;

    logic [P_LTC_WIDTH-1:0] ltc_q, ltc_d;
    logic [1:0]             trig_q, trig_d;
    logic                   cnst_q, cnst_d;
    logic [NW-1:0]          n_q, n_d;
    logic [NW-1:0]          issued_q, issued_d;
    logic [NW-1:0]          sent_q, sent_d;
    logic [P_RD_LAT-1:0]    vld_q, vld_d;
    logic [31:0]            evt_q, evt_d;

    logic [P_ADR_WIDTH-1:0]  hdr_start;
    logic [P_ADR_WIDTH-1:0]  hdr_stop;
    logic [P_ADR_WIDTH-1:0]  span;
    logic [P_DATA_WIDTH-1:0] skid_dout;
    logic [CW-1:0]           skid_cnt;
    logic                    skid_empty;
    logic                    skid_push;
    logic                    skid_pop;
    logic [31:0]             occ;
    logic                    rd_ok;
    logic                    last_samp;
    logic [15:0]             n16;
    logic                    unused_hdr;

    assign hdr_start  = hdr_data[START_LO +: P_ADR_WIDTH];
    assign hdr_stop   = hdr_data[STOP_LO +: P_ADR_WIDTH];
    assign span       = hdr_stop - hdr_start;
    assign unused_hdr = ^hdr_data[P_HDR_WIDTH-1:CNST_RUN_BIT+1];

    assign occ       = 32'(skid_cnt) + 32'($countones(vld_q));
    assign rd_ok     = (state_q == SAMP) && (issued_q < n_q)
                     && (occ < 32'(P_SKID_DEPTH));
    assign skid_push = vld_q[P_RD_LAT-1];
    assign last_samp = (sent_q == n_q - NW'(1));
    assign n16       = 16'(n_q);

    // Next-state, read issue and output word selection
    always_comb begin
        state_d    = state_q;
        ltc_d      = ltc_q;
        trig_d     = trig_q;
        cnst_d     = cnst_q;
        n_d        = n_q;
        issued_d   = issued_q + NW'(rd_ok);
        sent_d     = sent_q;
        vld_d      = (vld_q << 1) | P_RD_LAT'(rd_ok);
        evt_d      = evt_q;
        wvb_rdreq  = rd_ok;
        wvb_rddone = 1'b0;
        hdr_rdreq  = 1'b0;
        dout       = '0;
        dout_valid = 1'b0;
        dout_last  = 1'b0;
        skid_pop   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (en && !hdr_empty) begin
                    ltc_d    = hdr_data[LTC_LO +: P_LTC_WIDTH];
                    trig_d   = hdr_data[TRIG_SRC_LO +: 2];
                    cnst_d   = hdr_data[CNST_RUN_BIT];
                    n_d      = NW'(span) + NW'(1);
                    issued_d = '0;
                    sent_d   = '0;
                    state_d  = HDR0;
                end
            end
            HDR0: begin
                dout = {HDR_MAGIC, trig_q, cnst_q, 9'b0,
                        ltc_q[P_LTC_WIDTH-1 -: 16]};
                dout_valid = 1'b1;
                if (dout_ready) state_d = HDR1;
            end
            HDR1: begin
                dout       = ltc_q[31:0];
                dout_valid = 1'b1;
                if (dout_ready) state_d = HDR2;
            end
            HDR2: begin
                dout       = {16'h0, n16};
                dout_valid = 1'b1;
                if (dout_ready) state_d = SAMP;
            end
            SAMP: begin
                dout       = 32'(skid_dout);
                dout_valid = !skid_empty;
                dout_last  = last_samp;
                if (!skid_empty && dout_ready) begin
                    skid_pop = 1'b1;
                    sent_d   = sent_q + NW'(1);
                    if (last_samp) state_d = DONE;
                end
            end
            DONE: begin
                wvb_rddone = 1'b1;
                hdr_rdreq  = 1'b1;
                evt_d      = evt_q + 32'd1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and event registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ltc_q    <= '0;
            trig_q   <= '0;
            cnst_q   <= 1'b0;
            n_q      <= '0;
            issued_q <= '0;
            sent_q   <= '0;
            vld_q    <= '0;
            evt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ltc_q    <= ltc_d;
            trig_q   <= trig_d;
            cnst_q   <= cnst_d;
            n_q      <= n_d;
            issued_q <= issued_d;
            sent_q   <= sent_d;
            vld_q    <= vld_d;
            evt_q    <= evt_d;
        end
    end

    wvb_rd_skid_fifo #(
        .W     (P_DATA_WIDTH),
        .DEPTH (P_SKID_DEPTH)
    ) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (skid_push),
        .din   (wvb_data),
        .pop   (skid_pop),
        .dout  (skid_dout),
        .empty (skid_empty),
        .count (skid_cnt)
    );

    assign busy    = (state_q != IDLE);
    assign evt_cnt = evt_q;

endmodule

// File: tb/tb_wvb_reader.sv
// Directed bench for wvb_reader with header FIFO and RAM models.
// Inputs change 1ns after posedge; outputs are observed on negedge.
module tb_wvb_reader;
    import wvb_reader_pkg::*;

    localparam int DW = 28;
    localparam int AW = 15;
    localparam int HW = 87;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          dout_ready = 1'b0;
    logic          hdr_empty;
    logic [HW-1:0] hdr_data;
    logic          hdr_rdreq;
    logic [DW-1:0] wvb_data;
    logic          wvb_rdreq;
    logic          wvb_rddone;
    logic [31:0]   dout;
    logic          dout_valid;
    logic          dout_last;
    logic          busy;
    logic [31:0]   evt_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wvb_reader u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .hdr_empty  (hdr_empty),
        .hdr_data   (hdr_data),
        .hdr_rdreq  (hdr_rdreq),
        .wvb_data   (wvb_data),
        .wvb_rdreq  (wvb_rdreq),
        .wvb_rddone (wvb_rddone),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_last  (dout_last),
        .busy       (busy),
        .evt_cnt    (evt_cnt)
    );

    function automatic logic [DW-1:0] ram_f(input logic [AW-1:0] a);
        return {a[12:0] ^ 13'h15A5, a};
    endfunction

    function automatic logic [HW-1:0] mk_hdr(
        input logic [47:0] ltc, input logic [AW-1:0] st,
        input logic [AW-1:0] sp, input logic [1:0] trig,
        input logic cnst);
        return {6'h2A, cnst, trig, sp, st, ltc};
    endfunction

    // Header FIFO model (show-ahead)
    logic [HW-1:0] hq [0:7];
    int wr_idx = 0;
    int rd_idx = 0;
    assign hdr_empty = (wr_idx == rd_idx);
    assign hdr_data  = hq[rd_idx % 8];
    always @(posedge clk) begin
        if (rst_n && hdr_rdreq) rd_idx <= rd_idx + 1;
    end

    task automatic push_hdr(input logic [HW-1:0] h);
        hq[wr_idx % 8] = h;
        wr_idx = wr_idx + 1;
    endtask

    // Waveform RAM model: address loads from head header, 2-cycle read
    logic [AW-1:0] ra;
    logic [DW-1:0] p0, p1;
    logic [HW-1:0] head;
    assign head = hq[rd_idx % 8];
    always @(posedge clk) begin
        if (!busy && !hdr_empty) ra <= head[62:48];
        else if (wvb_rdreq) ra <= ra + 1'b1;
        p0 <= ram_f(ra);
        p1 <= p0;
    end
    assign wvb_data = p1;

    // Output monitor
    logic [32:0] cap [$];
    int rddone_cnt = 0;
    int hdrrd_cnt = 0;
    int stall_err = 0;
    int stall_seen = 0;
    int skid_err = 0;
    logic stall_prev = 1'b0;
    logic [31:0] prev_dout;
    logic prev_last;
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                stall_seen++;
                if (!dout_valid || dout !== prev_dout
                    || dout_last !== prev_last) stall_err++;
            end
            if (dout_valid && dout_ready) cap.push_back({dout_last, dout});
            stall_prev = dout_valid && !dout_ready;
            prev_dout  = dout;
            prev_last  = dout_last;
            if (wvb_rddone) rddone_cnt++;
            if (hdr_rdreq) hdrrd_cnt++;
            if (u_dut.u_skid.count_q > 3'd4) skid_err++;
            if (u_dut.skid_push && !u_dut.skid_pop
                && u_dut.u_skid.count_q == 3'd4) skid_err++;
            if (u_dut.skid_pop && u_dut.u_skid.count_q == 3'd0) skid_err++;
        end
    end

    task automatic wait_done(input int target, input int budget,
                             input string nm);
        for (int i = 0; i < budget && rddone_cnt < target; i++)
            @(posedge clk);
        #1;
        checks++;
        if (rddone_cnt < target) begin
            errors++;
            $display("FAIL %s timeout: rddone %0d required %0d",
                     nm, rddone_cnt, target);
        end
    endtask

    task automatic check_event(input string nm, input int base,
        input logic [47:0] ltc, input logic [AW-1:0] st,
        input logic [1:0] trig, input logic cnst, input int n);
        logic [32:0] exp_w [3];
        logic [AW-1:0] a;
        logic [32:0] e;
        exp_w[0] = {1'b0, 4'hA, trig, cnst, 9'b0, ltc[47:32]};
        exp_w[1] = {1'b0, ltc[31:0]};
        exp_w[2] = {1'b0, 16'h0, 16'(n)};
        checks++;
        if (cap.size() < base + 3 + n) begin
            errors++;
            $display("FAIL %s words: got %0d required %0d",
                     nm, cap.size() - base, 3 + n);
            return;
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (cap[base + i] !== exp_w[i]) begin
                errors++;
                $display("FAIL %s W%0d: got %h required %h",
                         nm, i, cap[base + i], exp_w[i]);
            end
        end
        checks++;
        for (int i = 0; i < n; i++) begin
            a = st + AW'(i);
            e = {(i == n - 1), 32'(ram_f(a))};
            if (cap[base + 3 + i] !== e) begin
                errors++;
                $display("FAIL %s sample %0d: got %h required %h",
                         nm, i, cap[base + 3 + i], e);
                break;
            end
        end
    endtask

    task automatic check_evt(input string nm, input int exp_n);
        checks++;
        if (evt_cnt !== 32'(exp_n)) begin
            errors++;
            $display("FAIL %s evt_cnt: got %0d required %0d",
                     nm, evt_cnt, exp_n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, dout_valid, dout_last, wvb_rdreq, hdr_rdreq,
             wvb_rddone} !== 6'b0) begin
            errors++;
            $display("FAIL reset ctl: got %b required 000000",
                     {busy, dout_valid, dout_last, wvb_rdreq,
                      hdr_rdreq, wvb_rddone});
        end
        checks++;
        if (dout !== 32'h0) begin
            errors++;
            $display("FAIL reset dout: got %h required 0", dout);
        end
        check_evt("reset", 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        int r0, h0;
        r0 = rddone_cnt;
        h0 = hdrrd_cnt;
        cap.delete();
        dout_ready = 1'b1;
        push_hdr(mk_hdr(48'h1234_5678_9ABC, 15'h0010, 15'h0013, 2'd2, 1'b1));
        en = 1'b1;
        wait_done(r0 + 1, 200, "single");
        en = 1'b0;
        check_event("single", 0, 48'h1234_5678_9ABC, 15'h0010,
                    2'd2, 1'b1, 4);
        checks++;
        if (cap.size() != 7 || hdrrd_cnt - h0 != 1) begin
            errors++;
            $display("FAIL single pulses: words %0d hdr_rdreq %0d required 7 1",
                     cap.size(), hdrrd_cnt - h0);
        end
        check_evt("single", 1);
    endtask

    task automatic test_wrap();
        int r0;
        r0 = rddone_cnt;
        cap.delete();
        push_hdr(mk_hdr(48'hFFFF_0000_1111, 15'h7FFE, 15'h0001, 2'd1, 1'b0));
        en = 1'b1;
        for (int i = 0; i < 20 && !busy; i++) @(posedge clk);
        #1;
        en = 1'b0;
        wait_done(r0 + 1, 200, "wrap");
        check_event("wrap", 0, 48'hFFFF_0000_1111, 15'h7FFE, 2'd1, 1'b0, 4);
        check_evt("wrap", 2);
    endtask

    task automatic test_degenerate();
        int r0;
        r0 = rddone_cnt;
        cap.delete();
        push_hdr(mk_hdr(48'h0000_0000_0042, 15'h1234, 15'h1234, 2'd3, 1'b1));
        en = 1'b1;
        wait_done(r0 + 1, 200, "n1");
        en = 1'b0;
        check_event("n1", 0, 48'h0000_0000_0042, 15'h1234, 2'd3, 1'b1, 1);
        check_evt("n1", 3);
    endtask

    task automatic test_full();
        int r0;
        r0 = rddone_cnt;
        cap.delete();
        push_hdr(mk_hdr(48'hABCD_EF01_2345, 15'h0100, 15'h00FF, 2'd0, 1'b0));
        en = 1'b1;
        wait_done(r0 + 1, 40000, "full");
        en = 1'b0;
        checks++;
        if (cap.size() > 2 && cap[2] !== {1'b0, 32'h0000_8000}) begin
            errors++;
            $display("FAIL full W2: got %h required 000008000", cap[2]);
        end
        check_event("full", 0, 48'hABCD_EF01_2345, 15'h0100,
                    2'd0, 1'b0, 32768);
        check_evt("full", 4);
    endtask

    task automatic test_backpressure();
        int r0;
        r0 = rddone_cnt;
        cap.delete();
        push_hdr(mk_hdr(48'h5555_AAAA_5555, 15'h0200, 15'h023F, 2'd1, 1'b1));
        en = 1'b1;
        for (int i = 0; i < 3000 && rddone_cnt < r0 + 1; i++) begin
            @(posedge clk);
            #1;
            dout_ready = ($urandom_range(0, 9) < 3);
        end
        dout_ready = 1'b1;
        en = 1'b0;
        wait_done(r0 + 1, 10, "bp");
        check_event("bp", 0, 48'h5555_AAAA_5555, 15'h0200, 2'd1, 1'b1, 64);
        checks++;
        if (stall_err != 0 || stall_seen == 0) begin
            errors++;
            $display("FAIL bp stable: unstable %0d stalls %0d required 0 and >0",
                     stall_err, stall_seen);
        end
        checks++;
        if (skid_err != 0) begin
            errors++;
            $display("FAIL bp skid: got %0d over/underflows required 0",
                     skid_err);
        end
        check_evt("bp", 5);
    endtask

    task automatic test_back_to_back();
        int r0, h0;
        r0 = rddone_cnt;
        h0 = hdrrd_cnt;
        cap.delete();
        push_hdr(mk_hdr(48'h0000_0000_0001, 15'h0300, 15'h0302, 2'd0, 1'b0));
        push_hdr(mk_hdr(48'h0000_0000_0002, 15'h0400, 15'h0404, 2'd1, 1'b1));
        push_hdr(mk_hdr(48'h0000_0000_0003, 15'h0500, 15'h0501, 2'd2, 1'b0));
        en = 1'b1;
        wait_done(r0 + 3, 500, "b2b");
        en = 1'b0;
        check_event("b2b0", 0, 48'h1, 15'h0300, 2'd0, 1'b0, 3);
        check_event("b2b1", 6, 48'h2, 15'h0400, 2'd1, 1'b1, 5);
        check_event("b2b2", 14, 48'h3, 15'h0500, 2'd2, 1'b0, 2);
        checks++;
        if (rddone_cnt - r0 != 3 || hdrrd_cnt - h0 != 3) begin
            errors++;
            $display("FAIL b2b pulses: rddone %0d hdr_rdreq %0d required 3 3",
                     rddone_cnt - r0, hdrrd_cnt - h0);
        end
        check_evt("b2b", 8);
    endtask

    task automatic test_reset_mid();
        int r0, h0;
        r0 = rddone_cnt;
        h0 = hdrrd_cnt;
        push_hdr(mk_hdr(48'h7777_7777_7777, 15'h0600, 15'h063F, 2'd3, 1'b1));
        en = 1'b1;
        for (int i = 0; i < 50 && u_dut.state_q != SAMP; i++) @(posedge clk);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, dout_valid, dout_last, wvb_rdreq, wvb_rddone,
             hdr_rdreq} !== 6'b0 || dout !== 32'h0) begin
            errors++;
            $display("FAIL rstmid outputs: ctl %b dout %h required 0 0",
                     {busy, dout_valid, dout_last, wvb_rdreq,
                      wvb_rddone, hdr_rdreq}, dout);
        end
        check_evt("rstmid", 0);
        wr_idx = rd_idx;
        en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (rddone_cnt != r0 || hdrrd_cnt != h0
            || u_dut.state_q != IDLE) begin
            errors++;
            $display("FAIL rstmid pulses: rddone %0d hdr_rdreq %0d required 0 0",
                     rddone_cnt - r0, hdrrd_cnt - h0);
        end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_en_low();
        int r0, h0;
        r0 = rddone_cnt;
        h0 = hdrrd_cnt;
        cap.delete();
        en = 1'b0;
        push_hdr(mk_hdr(48'h0BAD_CAFE_0001, 15'h0050, 15'h0051, 2'd1, 1'b0));
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || hdr_empty !== 1'b0 || hdrrd_cnt != h0
            || cap.size() != 0) begin
            errors++;
            $display("FAIL en_low idle: busy %b words %0d required 0 0",
                     busy, cap.size());
        end
        en = 1'b1;
        wait_done(r0 + 1, 200, "en_low");
        en = 1'b0;
        check_event("en_low", 0, 48'h0BAD_CAFE_0001, 15'h0050,
                    2'd1, 1'b0, 2);
        check_evt("en_low", 1);
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_degenerate();
        test_full();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_en_low();
        checks++;
        if (skid_err != 0) begin
            errors++;
            $display("FAIL skid overall: got %0d over/underflows required 0",
                     skid_err);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
